// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared defaults, port-map entry type and one-hot helper for regfile_read_arbiter.
package regfile_arb_pkg;
  localparam int NREQ_DEF = 4;
  localparam int AW_DEF = 6;
  localparam int DW_DEF = 72;
  localparam int IDX_W = 4;
  localparam int OHW = 1 << IDX_W;
  typedef logic [OHW-1:0] oh_t;
  typedef struct packed {
    logic valid;
    logic [IDX_W-1:0] idx;
  } pmap_t;
  function automatic logic [IDX_W-1:0] oh2idx(input oh_t oh);
    oh2idx = '0;
    for (int i = 0; i < OHW; i++) if (oh[i]) oh2idx = IDX_W'(i);
  endfunction
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-winner picker scanning req upward from rr_ptr with wraparound.
module rr_pick2 #(
  parameter int NREQ = 4,
  parameter int PW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] win1,
  output logic [NREQ-1:0] win2,
  output logic            v1,
  output logic            v2
);
  int j;
  always_comb begin
    win1 = '0;
    win2 = '0;
    v1 = 1'b0;
    v2 = 1'b0;
    j = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(rr_ptr) + i) % NREQ;
      if (req[j] && !v1) begin
        win1[j] = 1'b1;
        v1 = 1'b1;
      end else if (req[j] && !v2) begin
        win2[j] = 1'b1;
        v2 = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter: shares two synchronous register-file read ports among NREQ requesters.
// Define REGFILE_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module regfile_read_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]   gnt,
  output logic [AW-1:0]     rf_addr1,
  output logic [AW-1:0]     rf_addr2,
  input  logic [DW-1:0]     rf_data1,
  input  logic [DW-1:0]     rf_data2,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [NREQ*DW-1:0] rsp_data
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [PW-1:0] rr_ptr;
  logic [NREQ-1:0] win1, win2;
  logic v1, v2;
  logic [IDX_W-1:0] idx1, idx2;
  pmap_t pm1, pm2;
  // Masking requests at the picker input keeps gnt, addresses and the port map quiet together.
  rr_pick2 #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req(req & {NREQ{rst_n & ~stall}}),
    .rr_ptr(rr_ptr),
    .win1(win1),
    .win2(win2),
    .v1(v1),
    .v2(v2)
  );
  assign gnt = win1 | win2;
  assign idx1 = oh2idx(oh_t'(win1));
  assign idx2 = oh2idx(oh_t'(win2));
  always_comb begin
    rf_addr1 = '0;
    rf_addr2 = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win1[k]) rf_addr1 = req_addr[k*AW +: AW];
      if (win2[k]) rf_addr2 = req_addr[k*AW +: AW];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pm1 <= '0;
      pm2 <= '0;
    end else begin
      pm1 <= '{valid: v1, idx: idx1};
      pm2 <= '{valid: v2, idx: idx2};
    end
  always_comb begin
    rsp_valid = '0;
    rsp_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pm1.valid && pm1.idx == IDX_W'(k)) begin
        rsp_valid[k] = 1'b1;
        rsp_data[k*DW +: DW] = rf_data1;
      end
      if (pm2.valid && pm2.idx == IDX_W'(k)) begin
        rsp_valid[k] = 1'b1;
        rsp_data[k*DW +: DW] = rf_data2;
      end
    end
  end
`ifdef REGFILE_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [PW-1:0] last;
  assign last = v2 ? idx2[PW-1:0] : idx1[PW-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_ptr <= '0;
    else if (v1) rr_ptr <= (last == PW'(NREQ - 1)) ? '0 : last + 1'b1;
`endif
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb_regfile_read_arbiter: directed stimulus with a response scoreboard checked by an independent monitor.
module tb_regfile_read_arbiter;
  localparam int NREQ = 4;
  localparam int AW = 6;
  localparam int DW = 72;
  logic clk, rst_n, stall;
  logic [NREQ-1:0] req, gnt, rsp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [AW-1:0] rf_addr1, rf_addr2;
  logic [DW-1:0] rf_data1, rf_data2;
  logic [NREQ*DW-1:0] rsp_data;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  typedef struct {
    int due;
    logic [NREQ-1:0] v;
    logic [NREQ*DW-1:0] d;
  } exp_t;
  exp_t q[$];
  localparam logic [23:0] A = {6'h3F, 6'h2C, 6'h1A, 6'h05};
  localparam logic [23:0] B = {6'h3F, 6'h2C, 6'h1A, 6'h00};
  localparam logic [23:0] C = {6'h3F, 6'h2C, 6'h1A, 6'h3E};

  regfile_read_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .req(req), .req_addr(req_addr),
    .gnt(gnt), .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] rfv(input logic [AW-1:0] a, input bit p);
    rfv = {p ? 8'hB2 : 8'hA1, 52'h0, a, a};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rf_data1 <= rfv(rf_addr1, 1'b0);
    rf_data2 <= rfv(rf_addr2, 1'b1);
  end

  task automatic chk(input string name, input logic [NREQ*DW-1:0] act, input logic [NREQ*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic [3:0] r, input logic [23:0] a, input int p1, input int p2);
    logic [3:0] eg;
    logic [5:0] e1, e2;
    exp_t e;
    @(negedge clk);
    stall = s;
    req = r;
    req_addr = a;
    #2;
    eg = '0;
    e1 = '0;
    e2 = '0;
    e.due = cyc + 1;
    e.v = '0;
    e.d = '0;
    if (p1 >= 0) begin
      eg[p1] = 1'b1;
      e1 = a[p1*AW +: AW];
      e.v[p1] = 1'b1;
      e.d[p1*DW +: DW] = rfv(e1, 1'b0);
    end
    if (p2 >= 0) begin
      eg[p2] = 1'b1;
      e2 = a[p2*AW +: AW];
      e.v[p2] = 1'b1;
      e.d[p2*DW +: DW] = rfv(e2, 1'b1);
    end
    chk("gnt", gnt, eg);
    chk("rf_addr1", rf_addr1, e1);
    chk("rf_addr2", rf_addr2, e2);
    if (eg != 0) q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0 && q[0].due < cyc) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL rsp_missing due cycle %0d, now %0d, want valid %b", e.due, cyc, e.v);
      end else if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("rsp_valid", rsp_valid, e.v);
        chk("rsp_data", rsp_data, e.d);
      end else if (rsp_valid != 0 || rsp_data != 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected at cycle %0d: got valid %b want 0", cyc, rsp_valid);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    req = 4'b1111;
    req_addr = A;
    repeat (2) begin
      @(negedge clk);
      #2;
      chk("reset_gnt", gnt, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_data", rsp_data, 0);
    end
    req = 4'b0000;
    rst_n = 1'b1;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    step(0, 4'b1111, A, 0, 1);
    step(0, 4'b1111, A, 0, 1);
    step(0, 4'b1111, A, 0, 1);
    step(0, 4'b1010, A, 1, 3);
`else
    step(0, 4'b0001, A, 0, -1);
    step(0, 4'b0000, A, -1, -1);
    step(0, 4'b1000, A, 3, -1);
    step(0, 4'b1111, A, 0, 1);
    step(0, 4'b1111, A, 2, 3);
    step(0, 4'b1111, A, 0, 1);
    step(0, 4'b1010, A, 3, 1);
    step(0, 4'b0100, A, 2, -1);
    step(1, 4'b1111, A, -1, -1);
    step(0, 4'b1111, A, 3, 0);
    step(0, 4'b1111, A, 1, 2);
    step(0, 4'b0001, B, 0, -1);
    step(0, 4'b0001, C, 0, -1);
`endif
    step(0, 4'b0000, A, -1, -1);
    step(0, 4'b0000, A, -1, -1);
    @(negedge clk);
    req = 4'b0100;
    #2;
    chk("pre_reset_gnt", gnt, 4'b0100);
    #1;
    rst_n = 1'b0;
    #1;
    chk("reset_low_gnt", gnt, 0);
    repeat (2) begin
      @(negedge clk);
      #2;
      chk("mid_reset_gnt", gnt, 0);
      chk("mid_reset_rsp_valid", rsp_valid, 0);
      chk("mid_reset_rsp_data", rsp_data, 0);
    end
    req = 4'b0000;
    rst_n = 1'b1;
    step(0, 4'b1111, A, 0, 1);
    step(0, 4'b0000, A, -1, -1);
    repeat (2) @(negedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
